// File: rtl/fp_pkg.sv
// Shared definitions for the mini-float sign/zero resolver: default field widths,
// the operand-width helper and the resolved-result record carried by stage 2.
package fp_pkg;

  localparam int FP_EXP_W     = 3;
  localparam int FP_FRAC_W    = 4;
  // Widest exponent the result record can carry; narrower formats use the low bits.
  localparam int FP_EXP_W_MAX = 16;

  function automatic int fp_width(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  typedef struct packed {
    logic                    sign;
    logic                    zero;
    logic                    eff_sub;
    logic                    swap;
    logic [FP_EXP_W_MAX-1:0] exp_diff;
  } fp_sign_res_t;

endpackage

// File: rtl/mag_compare_n.sv
// Unsigned N-bit magnitude comparator, purely combinational.
module mag_compare_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/fp_sign_resolve_pipe.sv
// Two-stage sign/zero resolver for mini-float add/sub: exponent work in stage 1,
// fraction compare and final sign/zero/swap resolution in stage 2, globally stalled.
module fp_sign_resolve_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W    = FP_EXP_W,
  parameter int FRAC_W   = FP_FRAC_W,
  parameter int ZERO_ENC = 0,
  localparam int W       = fp_width(EXP_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic             zero,
  output logic             eff_sub,
  output logic             swap,
  output logic [EXP_W-1:0] exp_diff
);

  logic adv;

  logic              sa_p0, sb_p0, za_p0, zb_p0;
  logic [EXP_W-1:0]  exp_a_p0, exp_b_p0, exp_diff_p0;
  logic [FRAC_W-1:0] frac_a_p0, frac_b_p0;
  logic              exp_gt_p0, exp_eq_p0;

  logic              vld_p1;
  logic              sa_p1, sb_p1, eff_sub_p1, za_p1, zb_p1;
  logic              exp_gt_p1, exp_eq_p1;
  logic [EXP_W-1:0]  exp_diff_p1;
  logic [FRAC_W-1:0] frac_a_p1, frac_b_p1;
  logic              frac_gt_p1, frac_eq_p1;
  fp_sign_res_t      res_p1;

  logic              vld_p2;
  fp_sign_res_t      res_p2;
  logic              unused_exp_hi;

  assign adv      = ~vld_p2 | out_ready;
  assign in_ready = adv;

  function automatic fp_sign_res_t resolve(
    input logic             sa,
    input logic             sb,
    input logic             za,
    input logic             zb,
    input logic             gt,
    input logic             eq,
    input logic [EXP_W-1:0] ediff
  );
    fp_sign_res_t r;
    r                     = '0;
    r.eff_sub             = sa ^ sb;
    r.swap                = ~gt & ~eq;
    r.exp_diff[EXP_W-1:0] = ediff;
    if ((ZERO_ENC != 0) && za && zb) begin
      r.zero = 1'b1;
      r.sign = sa & sb;
    end else if ((ZERO_ENC != 0) && (za ^ zb)) begin
      r.sign = za ? sb : sa;
    end else if (!r.eff_sub) begin
      r.sign = sa;
    end else if (eq) begin
      r.zero = 1'b1;
    end else begin
      r.sign = gt ? sa : sb;
    end
    return r;
  endfunction

  // ---- stage 0: field split, exponent compare and difference
  assign sa_p0     = op_a[W-1];
  assign sb_p0     = op_b[W-1] ^ mode;
  assign exp_a_p0  = op_a[W-2 -: EXP_W];
  assign exp_b_p0  = op_b[W-2 -: EXP_W];
  assign frac_a_p0 = op_a[FRAC_W-1:0];
  assign frac_b_p0 = op_b[FRAC_W-1:0];
  assign za_p0     = ~|op_a[W-2:0];
  assign zb_p0     = ~|op_b[W-2:0];

  mag_compare_n #(.N(EXP_W)) u_exp_cmp (
    .a  (exp_a_p0),
    .b  (exp_b_p0),
    .gt (exp_gt_p0),
    .eq (exp_eq_p0)
  );

  // Subtract the smaller exponent from the larger so the difference never wraps.
  assign exp_diff_p0 = exp_gt_p0 ? (exp_a_p0 - exp_b_p0) : (exp_b_p0 - exp_a_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      sa_p1       <= 1'b0;
      sb_p1       <= 1'b0;
      eff_sub_p1  <= 1'b0;
      za_p1       <= 1'b0;
      zb_p1       <= 1'b0;
      exp_gt_p1   <= 1'b0;
      exp_eq_p1   <= 1'b0;
      exp_diff_p1 <= '0;
      frac_a_p1   <= '0;
      frac_b_p1   <= '0;
    end else if (adv) begin
      vld_p1      <= in_valid;
      sa_p1       <= sa_p0;
      sb_p1       <= sb_p0;
      eff_sub_p1  <= sa_p0 ^ sb_p0;
      za_p1       <= za_p0;
      zb_p1       <= zb_p0;
      exp_gt_p1   <= exp_gt_p0;
      exp_eq_p1   <= exp_eq_p0;
      exp_diff_p1 <= exp_diff_p0;
      frac_a_p1   <= frac_a_p0;
      frac_b_p1   <= frac_b_p0;
    end
  end

  // ---- stage 1: fraction compare breaks exponent ties, then resolve
  mag_compare_n #(.N(FRAC_W)) u_frac_cmp (
    .a  (frac_a_p1),
    .b  (frac_b_p1),
    .gt (frac_gt_p1),
    .eq (frac_eq_p1)
  );

  assign res_p1 = resolve(sa_p1, sb_p1, za_p1, zb_p1,
                          exp_gt_p1 | (exp_eq_p1 & frac_gt_p1),
                          exp_eq_p1 & frac_eq_p1,
                          exp_diff_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      res_p2 <= res_p1;
    end
  end

  // ---- stage 2: registered outputs
  assign out_valid     = vld_p2;
  assign sign          = res_p2.sign;
  assign zero          = res_p2.zero;
  assign eff_sub       = res_p2.eff_sub;
  assign swap          = res_p2.swap;
  assign exp_diff      = res_p2.exp_diff[EXP_W-1:0];
  assign unused_exp_hi = |(res_p2.exp_diff >> EXP_W);

  // eff_sub_p1 mirrors the resolved eff_sub; kept so stage 1 holds the full operation state.
  logic unused_eff_sub_p1;
  assign unused_eff_sub_p1 = eff_sub_p1;

endmodule
